// File: rtl/segment_dp.sv
// segment_dp: dynamic-programming segmentation accumulator fed by the E_min stage.
// Ports: clk_in/rst_in (async active-low) clock and reset; start_in begins a frame;
// emin_i_out/emin_valid_out trigger E_min for one end index; emin_j_in/emin_data_in/
// emin_valid_in carry its results; bound_out/bound_valid_out stream segment starts
// (last segment first); cost_out/done_out report total cost; busy_out is high outside IDLE.
module segment_dp #(
  parameter int BIT_WIDTH = 32,
  parameter int I = 160,
  localparam int IW = $clog2(I)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  output logic [IW-1:0]               emin_i_out,
  output logic                        emin_valid_out,
  input  logic [IW-1:0]               emin_j_in,
  input  logic signed [BIT_WIDTH-1:0] emin_data_in,
  input  logic                        emin_valid_in,
  output logic [IW-1:0]               bound_out,
  output logic                        bound_valid_out,
  output logic signed [BIT_WIDTH-1:0] cost_out,
  output logic                        done_out,
  output logic                        busy_out
);
  typedef enum logic [2:0] {IDLE, ISSUE, ACCUM, WRITE, TRACE, DONE} state_t;
  localparam logic [IW-1:0] LAST = IW'(I - 1);
  localparam logic signed [BIT_WIDTH-1:0] MAXV = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  state_t state_q, state_d;
  logic [IW-1:0] i_cnt_q, i_cnt_d, arg_q, arg_d, ptr_q, ptr_d;
  logic [IW-1:0] emin_i_q, emin_i_d, bound_q, bound_d;
  logic signed [BIT_WIDTH-1:0] best_q, best_d, cost_q, cost_d;
  logic emin_valid_q, emin_valid_d, bound_valid_q, bound_valid_d;
  logic done_q, done_d, busy_q, busy_d, wr;
  logic signed [BIT_WIDTH-1:0] f_q [I];
  logic [IW-1:0] b_q [I];
  logic signed [BIT_WIDTH-1:0] prev, cand;
  logic [BIT_WIDTH:0] sum;
  always_comb begin
    prev = (emin_j_in == '0) ? '0 : f_q[emin_j_in - 1'b1];
    sum = {prev[BIT_WIDTH-1], prev} + {emin_data_in[BIT_WIDTH-1], emin_data_in};
    // differing top two bits of the extended sum mean overflow; clamp toward its sign
    cand = (sum[BIT_WIDTH] != sum[BIT_WIDTH-1]) ? {sum[BIT_WIDTH], {(BIT_WIDTH-1){~sum[BIT_WIDTH]}}}
                                                : sum[BIT_WIDTH-1:0];
  end
  always_comb begin
    state_d = state_q;
    i_cnt_d = i_cnt_q;
    arg_d = arg_q;
    ptr_d = ptr_q;
    best_d = best_q;
    emin_i_d = emin_i_q;
    emin_valid_d = 1'b0;
    bound_d = bound_q;
    bound_valid_d = 1'b0;
    cost_d = cost_q;
    done_d = 1'b0;
    wr = 1'b0;
    case (state_q)
      IDLE: if (start_in) begin
        i_cnt_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        emin_i_d = i_cnt_q;
        emin_valid_d = 1'b1;
        best_d = MAXV;
        arg_d = '0;
        state_d = ACCUM;
      end
      ACCUM: if (emin_valid_in) begin
        // strict compare keeps the smallest j on ties
        if (cand < best_q) begin
          best_d = cand;
          arg_d = emin_j_in;
        end
        if (emin_j_in == i_cnt_q) state_d = WRITE;
      end
      WRITE: begin
        wr = 1'b1;
        if (i_cnt_q == LAST) begin
          ptr_d = LAST;
          state_d = TRACE;
        end else begin
          i_cnt_d = i_cnt_q + 1'b1;
          state_d = ISSUE;
        end
      end
      TRACE: begin
        bound_d = b_q[ptr_q];
        bound_valid_d = 1'b1;
        if (b_q[ptr_q] == '0) state_d = DONE;
        else ptr_d = b_q[ptr_q] - 1'b1;
      end
      DONE: begin
        cost_d = f_q[LAST];
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      i_cnt_q <= '0;
      arg_q <= '0;
      ptr_q <= '0;
      best_q <= '0;
      emin_i_q <= '0;
      emin_valid_q <= 1'b0;
      bound_q <= '0;
      bound_valid_q <= 1'b0;
      cost_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_cnt_q <= i_cnt_d;
      arg_q <= arg_d;
      ptr_q <= ptr_d;
      best_q <= best_d;
      emin_i_q <= emin_i_d;
      emin_valid_q <= emin_valid_d;
      bound_q <= bound_d;
      bound_valid_q <= bound_valid_d;
      cost_q <= cost_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  // F and B are fully rewritten every frame before being read, so they carry no reset
  always_ff @(posedge clk_in) begin
    if (wr) begin
      f_q[i_cnt_q] <= best_q;
      b_q[i_cnt_q] <= arg_q;
    end
  end
  assign emin_i_out = emin_i_q;
  assign emin_valid_out = emin_valid_q;
  assign bound_out = bound_q;
  assign bound_valid_out = bound_valid_q;
  assign cost_out = cost_q;
  assign done_out = done_q;
  assign busy_out = busy_q;
endmodule

// File: tb/tb_segment_dp.sv
// tb_segment_dp: table-driven, scoreboarded bench for segment_dp with I=4.
module tb_segment_dp;
  localparam int W = 32;
  localparam int N = 4;
  logic clk = 0, rst_in = 1, start_in = 0, emin_valid_in = 0;
  logic [1:0] emin_j_in = 0;
  logic signed [W-1:0] emin_data_in = 0;
  logic [1:0] emin_i_out, bound_out;
  logic emin_valid_out, bound_valid_out, done_out, busy_out;
  logic signed [W-1:0] cost_out;
  segment_dp #(.BIT_WIDTH(W), .I(N)) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .emin_i_out(emin_i_out), .emin_valid_out(emin_valid_out),
    .emin_j_in(emin_j_in), .emin_data_in(emin_data_in), .emin_valid_in(emin_valid_in),
    .bound_out(bound_out), .bound_valid_out(bound_valid_out),
    .cost_out(cost_out), .done_out(done_out), .busy_out(busy_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    int mode;
    int gap;
    bit stray;
    logic [31:0] cost;
    int nb;
    logic [3:0][1:0] bnd;
  } vec_t;
  vec_t v [6];
  int n_pass = 0, n_tot = 0, vo_cnt = 0;
  logic [1:0] exp_b [$];
  logic [31:0] exp_c [$];
  bit prev_bv = 0, prev_done = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic fail(input string name);
    n_tot++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask
  function automatic logic [31:0] emin_f(input int mode, input int i, input int j);
    case (mode)
      0: return 32'd10;
      1: return 32'((i - j + 1) * (i - j + 1));
      2: return (i == 0) ? 32'd2 : (i == 1) ? ((j == 0) ? 32'd4 : 32'd2) : ((j == i) ? 32'd1 : 32'd1000);
      3: return 32'h7FFF_FFF0;
      default: return 32'h8000_0010;
    endcase
  endfunction
  always @(negedge clk) begin
    if (emin_valid_out) vo_cnt++;
    if (bound_valid_out) begin
      if (exp_b.size() == 0) chk("bound_extra", {30'd0, bound_out}, 32'hFFFF_FFFF);
      else chk("bound", {30'd0, bound_out}, {30'd0, exp_b.pop_front()});
    end
    if (done_out) begin
      if (exp_c.size() == 0) chk("cost_extra", cost_out, 32'hDEAD_BEEF);
      else chk("cost", cost_out, exp_c.pop_front());
      chk("bounds_drained", exp_b.size(), 0);
      chk("done_follows_bound", {31'd0, prev_bv}, 1);
      chk("issue_count", vo_cnt, N);
      if (prev_done) chk("done_width", 2, 1);
    end
    prev_bv = bound_valid_out;
    prev_done = done_out;
  end
  task automatic wait_vo(output bit ok);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (emin_valid_out) begin
        ok = 1;
        return;
      end
    end
  endtask
  task automatic run_frame(input vec_t t);
    bit ok;
    vo_cnt = 0;
    for (int k = 0; k < t.nb; k++) exp_b.push_back(t.bnd[k]);
    exp_c.push_back(t.cost);
    @(negedge clk) start_in = 1;
    @(negedge clk) start_in = 0;
    for (int i = 0; i < N; i++) begin
      wait_vo(ok);
      if (!ok) begin
        fail("issue");
        exp_b.delete();
        exp_c.delete();
        return;
      end
      chk("emin_i", {30'd0, emin_i_out}, i);
      if (i == 0) chk("busy_run", {31'd0, busy_out}, 1);
      for (int j = 0; j <= i; j++) begin
        emin_j_in = 2'(j);
        emin_data_in = emin_f(t.mode, i, j);
        emin_valid_in = 1;
        @(negedge clk);
        emin_valid_in = 0;
        emin_data_in = $urandom;
        if (j < i) repeat (t.gap) begin
          start_in = t.stray;
          @(negedge clk);
          start_in = 0;
        end
      end
    end
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = done_out;
    end
    if (!ok) begin
      fail("done");
      exp_b.delete();
      exp_c.delete();
      return;
    end
    @(negedge clk);
    chk("done_cleared", {31'd0, done_out}, 0);
    chk("busy_idle", {31'd0, busy_out}, 0);
  endtask
  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_emin_i"}, {30'd0, emin_i_out}, 0);
    chk({tag, "_emin_valid"}, {31'd0, emin_valid_out}, 0);
    chk({tag, "_bound"}, {30'd0, bound_out}, 0);
    chk({tag, "_bound_valid"}, {31'd0, bound_valid_out}, 0);
    chk({tag, "_cost"}, cost_out, 0);
    chk({tag, "_done"}, {31'd0, done_out}, 0);
    chk({tag, "_busy"}, {31'd0, busy_out}, 0);
  endtask
  initial begin
    bit ok;
    v[0] = '{mode: 0, gap: 0, stray: 0, cost: 32'd10, nb: 1, bnd: {2'd0, 2'd0, 2'd0, 2'd0}};
    v[1] = '{mode: 1, gap: 0, stray: 0, cost: 32'd4, nb: 4, bnd: {2'd0, 2'd1, 2'd2, 2'd3}};
    v[2] = '{mode: 1, gap: 2, stray: 1, cost: 32'd4, nb: 4, bnd: {2'd0, 2'd1, 2'd2, 2'd3}};
    v[3] = '{mode: 2, gap: 1, stray: 0, cost: 32'd6, nb: 3, bnd: {2'd0, 2'd0, 2'd2, 2'd3}};
    v[4] = '{mode: 3, gap: 0, stray: 0, cost: 32'h7FFF_FFF0, nb: 1, bnd: {2'd0, 2'd0, 2'd0, 2'd0}};
    v[5] = '{mode: 4, gap: 0, stray: 0, cost: 32'h8000_0000, nb: 2, bnd: {2'd0, 2'd0, 2'd0, 2'd1}};
    #3 rst_in = 0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_in = 1;
    emin_j_in = 0;
    emin_data_in = -32'sd1000;
    emin_valid_in = 1;
    repeat (3) @(negedge clk);
    emin_valid_in = 0;
    chk("idle_stray_busy", {31'd0, busy_out}, 0);
    for (int k = 0; k < 6; k++) run_frame(v[k]);
    @(negedge clk) start_in = 1;
    @(negedge clk) start_in = 0;
    wait_vo(ok);
    if (!ok) fail("rst_issue0");
    emin_j_in = 0;
    emin_data_in = 1;
    emin_valid_in = 1;
    @(negedge clk) emin_valid_in = 0;
    wait_vo(ok);
    if (!ok) fail("rst_issue1");
    emin_j_in = 0;
    emin_data_in = 4;
    emin_valid_in = 1;
    @(negedge clk) emin_valid_in = 0;
    rst_in = 0;
    #1 chk_outputs_zero("midreset");
    @(negedge clk) rst_in = 1;
    @(negedge clk);
    chk("post_reset_busy", {31'd0, busy_out}, 0);
    run_frame(v[1]);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/segment_dp.md
# segment_dp

Dynamic-programming accumulator that sits directly downstream of the E_min stage in the formant/segmentation path. For each end index i = 0..I-1 it triggers the E_min stage, consumes that stage's stream of (j, Emin(j,i)) results, and computes the best total cost F(i) = min over j of F(j-1) + Emin(j,i), with F(-1) = 0, plus the arg-min back-pointer B(i). After the last i it backtraces B and streams out the segment start boundaries, then reports the total cost.

## Interface

Parameters:
- BIT_WIDTH, 32, width of signed Emin/cost values.
- I, 160, number of frame indices; index width IW = $clog2(I).

Ports:
- clk_in  input  1  the single clock.
- rst_in  input  1  **asynchronous, active-low** reset.
- start_in  input  1  one-cycle pulse that begins a frame. Ignored unless the block is in IDLE.
- emin_i_out  output  IW  i value handed to E_min; reset value 0.
- emin_valid_out  output  1  one-cycle start pulse to E_min; reset value 0.
- emin_j_in  input  IW  j tag of the incoming result.
- emin_data_in  input  BIT_WIDTH  signed Emin(j,i).
- emin_valid_in  input  1  result strobe.
- bound_out  output  IW  segment start index during backtrace; reset value 0.
- bound_valid_out  output  1  bound strobe; reset value 0.
- cost_out  output  BIT_WIDTH  signed total cost F(I-1); reset value 0.
- done_out  output  1  one-cycle frame-complete pulse; reset value 0.
- busy_out  output  1  high in every state except IDLE; reset value 0.

## Operation

- Storage: F[0..I-1] (signed, BIT_WIDTH bits) and B[0..I-1] (IW bits), both register arrays with combinational read. Working registers: i_cnt, best, arg, ptr.
- State machine: IDLE -> ISSUE -> ACCUM -> WRITE -> (ISSUE | TRACE) -> DONE -> IDLE.
- IDLE:
  - busy_out = 0.
  - start_in: i_cnt <= 0, go to ISSUE.
- ISSUE (1 cycle):
  - Register emin_i_out <= i_cnt and emin_valid_out <= 1; the pulse is 1 cycle wide.
  - best <= 2^(BIT_WIDTH-1)-1; arg <= 0.
  - Go to ACCUM.
- ACCUM, on each emin_valid_in:
  - prev = 0 if emin_j_in == 0, otherwise F[emin_j_in-1].
  - cand = prev + emin_data_in, computed signed with saturation to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
  - If cand < best (strict): best <= cand and arg <= emin_j_in. On a tie the earlier (smaller) j is kept.
  - If emin_j_in == i_cnt, this is the final sample: go to WRITE. Best/arg include this sample.
  - Cycles without emin_valid_in hold all state.
- WRITE (1 cycle):
  - F[i_cnt] <= best; B[i_cnt] <= arg.
  - If i_cnt == I-1: ptr <= I-1 and go to TRACE. Otherwise i_cnt <= i_cnt+1 and go to ISSUE.
- TRACE (1 cycle per segment):
  - bound_out <= B[ptr]; bound_valid_out <= 1.
  - If B[ptr] == 0, go to DONE. Otherwise ptr <= B[ptr]-1.
  - Bounds are emitted last segment first and always end with 0.
- DONE (1 cycle):
  - cost_out <= F[I-1]; done_out <= 1; go to IDLE.
  - cost_out holds its value until the next DONE.
- emin_valid_in outside ACCUM is ignored.
- start_in while busy is ignored.
- Reset (any time, including mid-ACCUM or mid-TRACE):
  - Immediately returns to IDLE and clears every output, i_cnt and ptr.
  - F and B are not cleared; they are fully rewritten before being read in the next frame.

## Timing

- start_in at cycle t: ISSUE at t+1, emin_valid_out high at t+2.
- Final result (j == i) accepted at cycle u: WRITE at u+1. Next emin_valid_out at u+3, or first TRACE at u+2 when i_cnt == I-1.
- Backtrace of s segments takes s cycles of consecutive bound_valid_out, followed by exactly one done_out cycle.
- Accepts one result per cycle, so it never back-pressures E_min.
- All outputs are registered.

## Test plan

- I=4, Emin(j,i) = 10 for all j,i -> F = {10,10,10,10}, B = {0,0,0,0}; one bound 0; cost_out = 10; done_out for exactly 1 cycle.
- I=4, Emin(j,i) = (i-j+1)^2 -> F = {1,2,3,4}, B = {0,1,2,3}; bounds 3,2,1,0 on consecutive cycles; cost_out = 4.
- Tie: I=2, Emin(0,0) = 2, Emin(0,1) = 4, Emin(1,1) = 2 -> both candidates equal 4; B[1] = 0; bounds: 0 only; cost 4.
- Saturation: I=2, all Emin = 0x7FFF_FFF0 -> j=1 candidate saturates to 0x7FFF_FFFF; B[1] = 0; cost_out = 0x7FFF_FFF0.
- Gaps and stray inputs: idle cycles inserted between results give identical results; emin_valid_in pulsed in IDLE and start_in pulsed mid-frame are both ignored; emin_valid_out fires exactly I times per frame.
- Reset mid-ACCUM: rst_in low for 1 cycle -> all outputs 0, busy_out 0; a subsequent start_in runs the scenario-2 frame correctly.
